dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised, byte-addressable data memory controller for the pipeline's MEM stage. It accepts one load or store request per handshake. It supports byte, halfword and word accesses with sign or zero extension on loads, and the read/write latency is configurable. Misaligned and out-of-range accesses are reported on an error flag instead of being silently truncated. It replaces the fixed-width, word-only data memory and its delay-based read/write timing with a fully clocked request/response protocol.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two, ≥4.
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.
- `INIT_INDEX`, 1: when 1, word i is initialised to i at time zero (simulation only). When 0, contents are undefined.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response strobe, for both loads and stores.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: response carries an error.

## Operation
- FSM states:
  - IDLE: ready=1, rsp_valid=0.
  - WAIT: ready=0, rsp_valid=0, down-counter `cnt`.
  - RESP: ready=1, rsp_valid=1.
- Accept = `req_valid && req_ready`. On accept, the request is latched, whatever is present on `req_*` at that edge.
- Transitions:
  - Accept from IDLE or RESP: go to RESP if LATENCY=1, else go to WAIT with cnt=LATENCY-1.
  - WAIT: decrement cnt; go to RESP on the edge where cnt==1.
  - RESP with no accept: go to IDLE.
- The access is performed on the edge entering RESP. On that edge the array write occurs and `rsp_rdata`/`rsp_err` are registered.
- Error conditions (rsp_err=1, no write, rsp_rdata=0):
  - `req_size`=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Address ≥ 4*DEPTH_WORDS.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Lanes are little-endian: byte offset k occupies bits [8k+7:8k].
- Stores write only the addressed lanes:
  - Byte: wdata[7:0] to lane addr[1:0].
  - Half: wdata[15:0] to lanes {addr[1],0}+1..0.
  - Word: all lanes.
- Loads extract the addressed byte or half, then extend per `req_unsigned`. `req_unsigned` is ignored for word loads and for all stores.
- No response back-pressure: the consumer must take `rsp_*` in the RESP cycle.
- `rsp_rdata`/`rsp_err` hold their last value outside RESP; the bench checks them only when `rsp_valid`=1.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, cnt=0.
- The array is not reset.
- Latency: `rsp_valid` is high exactly LATENCY cycles after the accepting edge.
- Throughput: one request per LATENCY cycles. With LATENCY=1, back-to-back requests give `rsp_valid` high on consecutive cycles.
- Accept in RESP: the response strobe for the old request and the acceptance of the new request occur in the same cycle.
- A load issued in the cycle after a store to the same word returns the new data, because the write completes before the load's access edge.
- Reset during WAIT: the pending request is dropped and no store is performed. Outputs take their reset values immediately (asynchronously).
- Reset during RESP: the array write for that request has already occurred.
- `req_*` changes while `req_ready`=0 are ignored.

## Test plan
1. Reset, INIT_INDEX=1, LATENCY=1: lw 0x10 → `rsp_valid` high 1 cycle after accept, rdata=0x00000004, err=0.
2. Byte store, then loads:
   - sb 0xA5 @0x21; then lb @0x21 → 0xFFFFFFA5.
   - lbu @0x21 → 0x000000A5.
   - lw @0x20 → 0x0000A508.
3. Half store, then loads:
   - sh 0x8001 @0x42; then lh @0x42 → 0xFFFF8001.
   - lhu → 0x00008001.
   - lw @0x40 → 0x80010010.
4. Errors:
   - lw @0x06 → err=1, rdata=0.
   - sw 0xDEADBEEF @0x03 → err=1; a following lw @0x00 → 0x00000000.
   - lw @0x400 (DEPTH_WORDS=256) → err=1.
   - size=11 → err=1.
5. LATENCY=3, req_valid held high with 4 loads @0x0,0x4,0x8,0xC:
   - ready low for 2 cycles after each accept.
   - rsp_valid at cycles 3,6,9,12.
   - rdata 0,1,2,3.
6. LATENCY=3, sw 0x12345678 @0x8, assert rst_n=0 one cycle after accept:
   - outputs zero immediately; ready=1 after release.
   - lw @0x8 → 0x00000002 (no write).

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory controller for the MEM stage.
// It accepts one load or store per req_valid/req_ready handshake and
// returns one rsp_valid strobe per request, LATENCY cycles after acceptance.
// It supports byte, half and word accesses. Loads are sign- or zero-extended.
// Misaligned, out-of-range and reserved-size accesses return rsp_err.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     request present
//   req_ready     controller accepts a request this cycle
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  zero-extend sub-word loads when 1
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     load result (0 for stores and errors)
//   rsp_err       response carries an error
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter bit INIT_INDEX  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [DEPTH_WORDS-1:0][31:0] mem_t;

  // Simulation-time contents: word i holds i when INIT_INDEX is set.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) m[i] = INIT_INDEX ? 32'(i) : 32'd0;
    return m;
  endfunction

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  mem_t mem = init_mem();

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;
  logic              do_access;

  logic              write_p0, unsigned_p0;
  logic [1:0]        size_p0;
  logic [31:0]       addr_p0, wdata_p0;

  logic              cur_write, cur_unsigned;
  logic [1:0]        cur_size, lane;
  logic [31:0]       cur_addr, cur_wdata;
  logic [AW-1:0]     idx;
  logic              acc_err;
  logic [31:0]       old_word, wr_word, rd_word;

  assign accept = req_valid && req_ready;

  // Entering RESP: either the WAIT countdown expires, or a single-cycle
  // access is accepted and performed on the same edge.
  assign do_access = (state == WAIT && cnt == CNT_W'(1)) ||
                     (accept && LATENCY == 1);

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state != WAIT);
    rsp_valid = (state == RESP);
  end

  // ---- p0: request latch (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0    <= req_write;
      size_p0     <= req_size;
      unsigned_p0 <= req_unsigned;
      addr_p0     <= req_addr;
      wdata_p0    <= req_wdata;
    end
  end

  // With LATENCY=1 the access happens on the accepting edge itself, so the
  // live request is used instead of the latched copy.
  always_comb begin
    cur_write    = (LATENCY == 1) ? req_write    : write_p0;
    cur_size     = (LATENCY == 1) ? req_size     : size_p0;
    cur_unsigned = (LATENCY == 1) ? req_unsigned : unsigned_p0;
    cur_addr     = (LATENCY == 1) ? req_addr     : addr_p0;
    cur_wdata    = (LATENCY == 1) ? req_wdata    : wdata_p0;
  end

  always_comb begin
    lane     = cur_addr[1:0];
    idx      = cur_addr[AW+1:2];
    old_word = mem[idx];
    case (cur_size)
      SZ_BYTE: acc_err = 1'b0;
      SZ_HALF: acc_err = lane[0];
      SZ_WORD: acc_err = |lane;
      default: acc_err = 1'b1;
    endcase
    if (|cur_addr[31:AW+2]) acc_err = 1'b1;

    wr_word = old_word;
    case (cur_size)
      SZ_BYTE: wr_word[{lane, 3'b000} +: 8]     = cur_wdata[7:0];
      SZ_HALF: wr_word[{lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
      default: wr_word = cur_wdata;
    endcase

    rd_word = (cur_write || acc_err) ? 32'd0
                                     : load_extend(old_word, cur_size, lane, cur_unsigned);
  end

  // ---- p1: array write and response registers ----
  always_ff @(posedge clk) begin
    if (do_access && cur_write && !acc_err) mem[idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= rd_word;
      rsp_err   <= acc_err;
    end
  end

endmodule
